// File: rtl/delay_pkg.sv
// Shared constants for the delay line controller: default widths,
// FSM state encoding and the saturation bounds of the default sample width.
package delay_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 14;
    localparam int DEF_GAIN_WIDTH = 8;

    // Gains are Q0.8, so every product is rescaled by this many bits
    localparam int GAIN_SHIFT = 8;

    // One state per cycle of the per-sample sequence
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WT   = 3'd2;
    localparam logic [2:0] ST_MAC  = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;

    // Clamp limits for a DEF_DATA_WIDTH two's complement sample
    localparam int SAT_MAX = (1 << (DEF_DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(1 << (DEF_DATA_WIDTH - 1));

endpackage

// File: rtl/sat_mac.sv
// Combinational saturating multiply-accumulate: y = sat(x + (d*gain) >>> 8).
// The gain is unsigned Q0.8; a zero bit is prepended so it multiplies as a
// non-negative signed value, and the arithmetic shift floors toward -inf.
module sat_mac
    import delay_pkg::*;
#(
    parameter int DW = DEF_DATA_WIDTH,
    parameter int GW = DEF_GAIN_WIDTH
) (
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] d,
    input  logic        [GW-1:0] gain,
    output logic signed [DW-1:0] y
);

    localparam int PW = DW + GW + 1;
    localparam int SW = DW + 1;
    localparam logic signed [DW-1:0] Y_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] Y_MIN = {1'b1, {(DW-1){1'b0}}};

    logic signed [GW:0]   gain_s;
    logic signed [PW-1:0] product;
    logic signed [PW-1:0] scaled;
    logic signed [SW-1:0] sum;

    // Scaled product fits in DW bits (|gain| < 1), so the sum needs only one guard bit
    always_comb begin
        gain_s  = {1'b0, gain};
        product = d * gain_s;
        scaled  = product >>> GAIN_SHIFT;
        sum     = SW'(x) + SW'(scaled);
        if (sum[DW] != sum[DW-1]) begin
            y = sum[DW] ? Y_MIN : Y_MAX;
        end else begin
            y = DW'(sum);
        end
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Echo/delay engine in front of a 1RW/1R delay SRAM. Each accepted sample
// walks IDLE->RD->WT->MAC->WR: read the delayed sample on port 1, write
// input+feedback on port 0, and present dry+wet on out_sample.
module delay_line_ctrl
    import delay_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int GAIN_WIDTH = DEF_GAIN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] delay_len,
    input  logic [GAIN_WIDTH-1:0] fb_gain,
    input  logic [GAIN_WIDTH-1:0] mix_gain,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_sample,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_sample,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int GW = GAIN_WIDTH;

    // Full-depth count, one bit wider than an address
    localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

    logic [2:0]           state;
    logic signed [DW-1:0] x_reg;
    logic signed [DW-1:0] dly;
    logic signed [DW-1:0] wet;
    logic signed [DW-1:0] wrv;
    logic [AW:0]          eff_in;
    logic [AW:0]          eff_reg;
    logic [GW-1:0]        fb_reg;
    logic [GW-1:0]        mix_reg;
    logic                 en_reg;
    logic [AW-1:0]        wr_ptr;
    logic [AW:0]          fill_cnt;

    // Port 0 only ever writes
    assign sram_web0 = 1'b0;
    assign in_ready  = (state == ST_IDLE);

    // A zero delay length selects the whole memory depth
    always_comb begin
        eff_in = (delay_len == '0) ? DEPTH_CNT : {1'b0, delay_len};
    end

    // Sequencer: exactly one cycle in each state, new samples only in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) state <= ST_RD;
                ST_RD:   state <= ST_WT;
                ST_WT:   state <= ST_MAC;
                ST_MAC:  state <= ST_WR;
                ST_WR:   state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Snapshot the sample and all controls so mid-sample changes cannot glitch it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg   <= '0;
            eff_reg <= '0;
            fb_reg  <= '0;
            mix_reg <= '0;
            en_reg  <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            x_reg   <= in_sample;
            eff_reg <= eff_in;
            fb_reg  <= fb_gain;
            mix_reg <= mix_gain;
            en_reg  <= en;
        end
    end

    // Capture the delayed sample, masking slots never written since reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly <= '0;
        end else if (state == ST_WT) begin
            if ((fill_cnt < eff_reg) || !en_reg) begin
                dly <= '0;
            end else begin
                dly <= sram_dout1;
            end
        end
    end

    // Write pointer wraps with the address width; fill count stops at full depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
        end else if (state == ST_WR) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (fill_cnt != DEPTH_CNT) begin
                fill_cnt <= fill_cnt + (AW+1)'(1);
            end
        end
    end

    // Read port: one-cycle select in RD; the address wraps modulo depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_csb1  <= 1'b1;
            sram_addr1 <= '0;
        end else if (state == ST_IDLE && in_valid) begin
            sram_csb1  <= 1'b0;
            sram_addr1 <= wr_ptr - eff_in[AW-1:0];
        end else begin
            sram_csb1  <= 1'b1;
        end
    end

    // Write port and output strobe are both driven for the single WR cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_csb0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else if (state == ST_MAC) begin
            sram_csb0  <= 1'b0;
            sram_addr0 <= wr_ptr;
            sram_din0  <= wrv;
            out_valid  <= 1'b1;
            out_sample <= wet;
        end else begin
            sram_csb0  <= 1'b1;
            out_valid  <= 1'b0;
        end
    end

    // Wet output path
    sat_mac #(.DW(DW), .GW(GW)) u_wet_mac (
        .x    (x_reg),
        .d    (dly),
        .gain (mix_reg),
        .y    (wet)
    );

    // Feedback path into the delay memory
    sat_mac #(.DW(DW), .GW(GW)) u_fb_mac (
        .x    (x_reg),
        .d    (dly),
        .gain (fb_reg),
        .y    (wrv)
    );

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: a 16K-deep instance (a) and a 16-deep instance (b)
// share clock, reset and controls. Each has a behavioural SRAM and a scoreboard
// whose reference model keeps the full history of written samples.
module tb_delay_line_ctrl;

    localparam int DW  = 16;
    localparam int GW  = 8;
    localparam int AWA = 14;
    localparam int AWB = 4;
    localparam int DEPTH_A = 1 << AWA;
    localparam int DEPTH_B = 1 << AWB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic [AWA-1:0] delay_len = '0;
    logic [GW-1:0] fb_gain = '0;
    logic [GW-1:0] mix_gain = '0;
    logic [DW-1:0] in_sample = '0;
    logic in_valid_a = 1'b0;
    logic in_valid_b = 1'b0;

    logic in_ready_a, out_valid_a, csb0_a, web0_a, csb1_a;
    logic [DW-1:0] out_sample_a, din0_a, dout1_a;
    logic [AWA-1:0] addr0_a, addr1_a;
    logic in_ready_b, out_valid_b, csb0_b, web0_b, csb1_b;
    logic [DW-1:0] out_sample_b, din0_b, dout1_b;
    logic [AWB-1:0] addr0_b, addr1_b;

    logic [DW-1:0] mem_a [0:DEPTH_A-1];
    logic [DW-1:0] mem_b [0:DEPTH_B-1];

    typedef struct {
        int wet;
        int wrv;
        int addr;
        int cyc;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int hist_a[$];
    int hist_b[$];
    int outs_a[$];
    int outs_b[$];
    int addrs_b[$];
    int acc_b = 0;
    int ov_b = 0;
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    delay_line_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWA), .GAIN_WIDTH(GW)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .delay_len(delay_len),
        .fb_gain(fb_gain), .mix_gain(mix_gain), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .in_sample(in_sample), .out_valid(out_valid_a),
        .out_sample(out_sample_a), .sram_csb0(csb0_a), .sram_web0(web0_a),
        .sram_addr0(addr0_a), .sram_din0(din0_a), .sram_csb1(csb1_a),
        .sram_addr1(addr1_a), .sram_dout1(dout1_a)
    );

    delay_line_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWB), .GAIN_WIDTH(GW)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .delay_len(delay_len[AWB-1:0]),
        .fb_gain(fb_gain), .mix_gain(mix_gain), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .in_sample(in_sample), .out_valid(out_valid_b),
        .out_sample(out_sample_b), .sram_csb0(csb0_b), .sram_web0(web0_b),
        .sram_addr0(addr0_b), .sram_din0(din0_b), .sram_csb1(csb1_b),
        .sram_addr1(addr1_b), .sram_dout1(dout1_b)
    );

    // Synchronous SRAM models: write on port 0, registered read on port 1
    always @(posedge clk) begin
        if (!csb0_a && !web0_a) mem_a[addr0_a] <= din0_a;
        if (!csb1_a) dout1_a <= mem_a[addr1_a];
        if (!csb0_b && !web0_b) mem_b[addr0_b] <= din0_b;
        if (!csb1_b) dout1_b <= mem_b[addr1_b];
    end

    task automatic check_output(input string tag, input int obs, input int exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: x + floor(d*g/256), clamped to 16-bit signed
    function automatic int mac_model(input int x, input int d, input int g);
        int s;
        s = x + ((d * g) >>> 8);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s;
    endfunction

    // Scoreboards sample away from the active edge; reset discards all history
    always @(negedge clk) begin
        exp_t e;
        int n, eff, d, x;
        cyc++;
        if (!rst_n) begin
            hist_a.delete(); exp_a.delete();
            hist_b.delete(); exp_b.delete();
        end else begin
            if (out_valid_a) begin
                outs_a.push_back(int'($signed(out_sample_a)));
                if (exp_a.size() == 0) begin
                    check_output("a_spurious_out_valid", 1, 0);
                end else begin
                    e = exp_a.pop_front();
                    check_output("a_latency", cyc - e.cyc, 4);
                    check_output("a_out_sample", $signed(out_sample_a), e.wet);
                    check_output("a_wr_data", $signed(din0_a), e.wrv);
                    check_output("a_wr_addr", int'(addr0_a), e.addr);
                    check_output("a_wr_strobe", int'({csb0_a, web0_a}), 0);
                    check_output("a_out_known", int'($isunknown(out_sample_a)), 0);
                end
            end
            if (in_valid_a && in_ready_a) begin
                n = hist_a.size();
                eff = (delay_len == 0) ? DEPTH_A : int'(delay_len);
                d = (en && n >= eff) ? hist_a[n - eff] : 0;
                x = $signed(in_sample);
                e.wet = mac_model(x, d, int'(mix_gain));
                e.wrv = mac_model(x, d, int'(fb_gain));
                e.addr = n % DEPTH_A;
                e.cyc = cyc;
                hist_a.push_back(e.wrv);
                exp_a.push_back(e);
            end
            if (out_valid_b) begin
                ov_b++;
                outs_b.push_back(int'($signed(out_sample_b)));
                addrs_b.push_back(int'(addr0_b));
                if (exp_b.size() == 0) begin
                    check_output("b_spurious_out_valid", 1, 0);
                end else begin
                    e = exp_b.pop_front();
                    check_output("b_latency", cyc - e.cyc, 4);
                    check_output("b_out_sample", $signed(out_sample_b), e.wet);
                    check_output("b_wr_data", $signed(din0_b), e.wrv);
                    check_output("b_wr_addr", int'(addr0_b), e.addr);
                    check_output("b_wr_strobe", int'({csb0_b, web0_b}), 0);
                end
            end
            if (in_valid_b && in_ready_b) begin
                acc_b++;
                n = hist_b.size();
                eff = (delay_len[AWB-1:0] == 0) ? DEPTH_B : int'(delay_len[AWB-1:0]);
                d = (en && n >= eff) ? hist_b[n - eff] : 0;
                x = $signed(in_sample);
                e.wet = mac_model(x, d, int'(mix_gain));
                e.wrv = mac_model(x, d, int'(fb_gain));
                e.addr = n % DEPTH_B;
                e.cyc = cyc;
                hist_b.push_back(e.wrv);
                exp_b.push_back(e);
            end
        end
    end

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drain(2);
        rst_n = 1'b1;
    endtask

    // Offer one sample to instance 0 (a) or 1 (b) once it is ready
    task automatic apply_stimulus(input int inst, input int x, input int dl,
                                  input int fb, input int mix, input bit en_i);
        int waited = 0;
        while (!(inst == 0 ? in_ready_a : in_ready_b) && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) check_output("in_ready_timeout", 0, 1);
        in_sample = 16'(x);
        delay_len = 14'(dl);
        fb_gain = 8'(fb);
        mix_gain = 8'(mix);
        en = en_i;
        if (inst == 0) in_valid_a = 1'b1;
        else in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base, ov0, acc0;
        int t2 [9] = '{16000, 0, 0, 0, 8000, 0, 0, 0, 0};
        int ins [100];

        // Reset state while rst_n is held low
        drain(2);
        check_output("rst_in_ready", int'(in_ready_a), 1);
        check_output("rst_out_valid", int'(out_valid_a), 0);
        check_output("rst_out_sample", int'(out_sample_a), 0);
        check_output("rst_csb0", int'(csb0_a), 1);
        check_output("rst_csb1", int'(csb1_a), 1);
        check_output("rst_b_csb", int'({csb0_b, csb1_b}), 3);
        rst_n = 1'b1;
        drain(1);

        // Impulse with fb=0: a single half-level echo 4 samples later
        do_reset();
        base = outs_a.size();
        apply_stimulus(0, 16000, 4, 0, 'h80, 1'b1);
        for (int i = 1; i < 9; i++) apply_stimulus(0, 0, 4, 0, 'h80, 1'b1);
        drain(8);
        check_output("t2_count", outs_a.size() - base, 9);
        for (int i = 0; i < 9; i++) check_output("t2_out", outs_a[base + i], t2[i]);

        // Feedback impulse train and stored feedback value
        do_reset();
        base = outs_a.size();
        apply_stimulus(0, 16384, 2, 'h80, 'hFF, 1'b1);
        for (int i = 1; i < 5; i++) apply_stimulus(0, 0, 2, 'h80, 'hFF, 1'b1);
        drain(8);
        check_output("t3_out0", outs_a[base], 16384);
        check_output("t3_out2", outs_a[base + 2], 16320);
        check_output("t3_out4", outs_a[base + 4], 8160);
        check_output("t3_mem2", int'($signed(mem_a[2])), 8192);

        // Saturation at both rails, on the output and in the stored value
        do_reset();
        base = outs_a.size();
        for (int i = 0; i < 3; i++) apply_stimulus(0, 30000, 1, 'hFF, 'hFF, 1'b1);
        drain(8);
        check_output("t4_pos_out1", outs_a[base + 1], 32767);
        check_output("t4_pos_out2", outs_a[base + 2], 32767);
        check_output("t4_pos_mem1", int'($signed(mem_a[1])), 32767);
        do_reset();
        base = outs_a.size();
        for (int i = 0; i < 3; i++) apply_stimulus(0, -30000, 1, 'hFF, 'hFF, 1'b1);
        drain(8);
        check_output("t4_neg_out1", outs_a[base + 1], -32768);
        check_output("t4_neg_out2", outs_a[base + 2], -32768);
        check_output("t4_neg_mem1", int'($signed(mem_a[1])), -32768);

        // Garbage-filled memory must stay masked until it has been written
        do_reset();
        for (int i = 0; i < DEPTH_A; i++) mem_a[i] <= 16'($urandom);
        drain(1);
        base = outs_a.size();
        for (int i = 0; i < 100; i++) begin
            ins[i] = $urandom_range(0, 40000) - 20000;
            apply_stimulus(0, ins[i], 100, $urandom_range(0, 255), 'hFF, 1'b1);
        end
        for (int i = 0; i < 10; i++) apply_stimulus(0, 0, 100, 0, 'hFF, 1'b1);
        drain(8);
        for (int i = 0; i < 100; i++) check_output("t5_dry_only", outs_a[base + i], ins[i]);

        // Randomized traffic on the deep instance
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(0, $urandom_range(0, 65535) - 32768,
                           ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6),
                           $urandom_range(0, 255), $urandom_range(0, 255),
                           $urandom_range(0, 3) != 0);
        end
        drain(8);

        // Full-depth delay on the 16-deep instance: pointer wrap and echo at 16
        do_reset();
        base = outs_b.size();
        apply_stimulus(1, 1000, 0, 0, 'hFF, 1'b1);
        for (int i = 1; i < 17; i++) apply_stimulus(1, 0, 0, 0, 'hFF, 1'b1);
        drain(8);
        check_output("t6_out15", outs_b[base + 15], 0);
        check_output("t6_out16", outs_b[base + 16], 996);
        check_output("t6_addr15", addrs_b[base + 15], 15);
        check_output("t6_addr16", addrs_b[base + 16], 0);

        // in_valid held high: one acceptance per five cycles
        in_sample = 16'd500;
        delay_len = 14'd3;
        acc0 = acc_b;
        in_valid_b = 1'b1;
        repeat (25) @(negedge clk);
        #1;
        check_output("t6_held_accepts", acc_b - acc0, 5);
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        drain(8);

        // Reset during RD: read select released at once, sample dropped
        apply_stimulus(1, 1234, 3, 0, 'hFF, 1'b1);
        check_output("t6_rd_csb1_low", int'(csb1_b), 0);
        rst_n = 1'b0;
        #1;
        check_output("t6_rd_rst_csb", int'({csb0_b, csb1_b}), 3);
        check_output("t6_rd_rst_ready", int'(in_ready_b), 1);
        drain(1);
        rst_n = 1'b1;
        ov0 = ov_b;
        drain(8);
        check_output("t6_rd_no_out", ov_b - ov0, 0);

        // Reset during WT: no output for the in-flight sample
        apply_stimulus(1, 4321, 3, 0, 'hFF, 1'b1);
        drain(1);
        rst_n = 1'b0;
        #1;
        check_output("t6_wt_rst_csb", int'({csb0_b, csb1_b}), 3);
        check_output("t6_wt_rst_valid", int'(out_valid_b), 0);
        drain(1);
        rst_n = 1'b1;
        ov0 = ov_b;
        drain(8);
        check_output("t6_wt_no_out", ov_b - ov0, 0);

        // Randomized traffic on the shallow instance, including full-depth delays
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(1, $urandom_range(0, 65535) - 32768, $urandom_range(0, 15),
                           $urandom_range(0, 255), $urandom_range(0, 255),
                           $urandom_range(0, 3) != 0);
        end
        drain(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
